seq_divider_16by8: RTL and testbench

//  Sequential restoring divider: 16-bit unsigned dividend / 8-bit unsigned divisor -> 16-bit quotient, 8-bit remainder.

---
 rtl/seq_divider_16by8_if.sv | 25 ++
 rtl/seq_divider_16by8.sv | 132 +++++++++++++
 tb/tb_seq_divider_16by8.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_16by8_if.sv
// Handshake and result bundle for the 16/8 sequential divider.
// The requester drives start and the operands; the divider returns the results and status.
interface seq_divider_16by8_if #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8
);
    logic                  start;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  busy;
    logic                  done_flag;
    logic                  div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done_flag, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done_flag, div_by_zero
    );
endinterface

// File: rtl/seq_divider_16by8.sv
// Radix-2 restoring divider: one quotient bit per clock, 16-bit dividend by 8-bit divisor.
// Divide-by-zero skips the iteration loop and reports all-ones quotient, dividend low byte as remainder.
//
// state  | meaning
// S_IDLE | waiting for start; operands captured on an accepted start
// S_CALC | one shift/trial-subtract iteration per clock, 16 in total
// S_DONE | results valid, done_flag pulses for one cycle (div-by-zero loads results here)
module seq_divider_16by8 #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8
) (
    input  logic                clk,
    input  logic                reset_a,
    seq_divider_16by8_if.slave  bus
);

    localparam int                CNT_W    = $clog2(DIVIDEND_W);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIVIDEND_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q,       state_d;
    logic [CNT_W-1:0]      count_q,       count_d;
    logic [DIVISOR_W-1:0]  pr_q,          pr_d;
    logic [DIVIDEND_W-1:0] q_q,           q_d;
    logic [DIVISOR_W-1:0]  dvs_q,         dvs_d;
    logic [DIVIDEND_W-1:0] quotient_q,    quotient_d;
    logic [DIVISOR_W-1:0]  remainder_q,   remainder_d;
    logic                  done_flag_q,   done_flag_d;
    logic                  div_by_zero_q, div_by_zero_d;

    logic [DIVISOR_W:0]    pr_shift;
    logic [DIVISOR_W:0]    trial;
    logic                  fits;
    logic [DIVISOR_W-1:0]  pr_next;
    logic [DIVIDEND_W-1:0] q_next;

    // Partial remainder stays below the divisor, so the shifted value is < 2*divisor:
    // the trial difference's top bit is exactly the borrow of the compare.
    always_comb begin
        pr_shift = {pr_q, q_q[DIVIDEND_W-1]};
        trial    = pr_shift - {1'b0, dvs_q};
        fits     = ~trial[DIVISOR_W];
        pr_next  = fits ? trial[DIVISOR_W-1:0] : pr_shift[DIVISOR_W-1:0];
        q_next   = {q_q[DIVIDEND_W-2:0], fits};
    end

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        pr_d          = pr_q;
        q_d           = q_q;
        dvs_d         = dvs_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        done_flag_d   = 1'b0;
        div_by_zero_d = div_by_zero_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    q_d           = bus.dividend;
                    dvs_d         = bus.divisor;
                    pr_d          = '0;
                    count_d       = '0;
                    div_by_zero_d = 1'b0;
                    state_d       = (bus.divisor == '0) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                pr_d    = pr_next;
                q_d     = q_next;
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_LAST) begin
                    quotient_d  = q_next;
                    remainder_d = pr_next;
                    done_flag_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (done_flag_q) begin
                    state_d = S_IDLE;
                end else begin
                    // Entered straight from IDLE with a zero divisor: publish the fixed result now.
                    quotient_d    = '1;
                    remainder_d   = q_q[DIVISOR_W-1:0];
                    done_flag_d   = 1'b1;
                    div_by_zero_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            state_q       <= S_IDLE;
            count_q       <= '0;
            pr_q          <= '0;
            q_q           <= '0;
            dvs_q         <= '0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            done_flag_q   <= 1'b0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            pr_q          <= pr_d;
            q_q           <= q_d;
            dvs_q         <= dvs_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            done_flag_q   <= done_flag_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.done_flag   = done_flag_q;
    assign bus.div_by_zero = div_by_zero_q;
    assign bus.busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_seq_divider_16by8.sv
// Directed bench for the 16/8 sequential divider: latency, results, divide-by-zero,
// start-while-busy, back-to-back issue and asynchronous reset mid-operation.
module tb_seq_divider_16by8;

    logic clk;
    logic reset_a;
    int   checks;
    int   errors;

    seq_divider_16by8_if dif ();

    seq_divider_16by8 dut (
        .clk     (clk),
        .reset_a (reset_a),
        .bus     (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Caller sits at a falling edge; returns at the falling edge after the start edge E0.
    task automatic issue(input logic [15:0] a, input logic [7:0] b);
        dif.start    = 1'b1;
        dif.dividend = a;
        dif.divisor  = b;
        @(posedge clk);
        @(negedge clk);
        dif.start    = 1'b0;
        dif.dividend = 16'hDEAD;
        dif.divisor  = 8'h5A;
    endtask

    // Counts falling edges until done_flag; lat is the number of clocks since the start edge.
    task automatic wait_done(input int base, output int lat);
        lat = base;
        while (dif.done_flag !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        reset_a = 1'b0;
        dif.start = 1'b0;
        dif.dividend = '0;
        dif.divisor = '0;
        #3;
        checks++;
        if ({dif.quotient, dif.remainder, dif.busy, dif.done_flag, dif.div_by_zero} !== 27'd0) begin
            errors++;
            $display("FAIL reset_outputs: got q=%0d r=%0d busy=%b done=%b dz=%b, expected all 0",
                     dif.quotient, dif.remainder, dif.busy, dif.done_flag, dif.div_by_zero);
        end
        @(negedge clk);
        reset_a = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat;
        issue(16'd1000, 8'd7);
        checks++;
        if (dif.busy !== 1'b1) begin
            errors++; $display("FAIL basic_busy: got %b, expected 1", dif.busy);
        end
        wait_done(0, lat);
        checks++;
        if (lat != 16) begin
            errors++; $display("FAIL basic_latency: got %0d, expected 16", lat);
        end
        checks++;
        if (dif.quotient !== 16'd142 || dif.remainder !== 8'd6 || dif.div_by_zero !== 1'b0) begin
            errors++; $display("FAIL basic_result: got q=%0d r=%0d dz=%b, expected q=142 r=6 dz=0",
                               dif.quotient, dif.remainder, dif.div_by_zero);
        end
        checks++;
        if (int'(dif.quotient) * 7 + int'(dif.remainder) != 1000 || dif.remainder >= 8'd7) begin
            errors++; $display("FAIL basic_invariant: got q=%0d r=%0d for 1000/7", dif.quotient, dif.remainder);
        end
        @(negedge clk);
        checks++;
        if (dif.done_flag !== 1'b0 || dif.busy !== 1'b0 || dif.quotient !== 16'd142) begin
            errors++; $display("FAIL basic_after_done: got done=%b busy=%b q=%0d, expected done=0 busy=0 q=142",
                               dif.done_flag, dif.busy, dif.quotient);
        end
    endtask

    task automatic test_extremes();
        int lat;
        issue(16'hFFFF, 8'd1);
        wait_done(0, lat);
        checks++;
        if (lat != 16 || dif.quotient !== 16'd65535 || dif.remainder !== 8'd0) begin
            errors++; $display("FAIL ffff_by_1: got lat=%0d q=%0d r=%0d, expected lat=16 q=65535 r=0",
                               lat, dif.quotient, dif.remainder);
        end
        @(negedge clk);
        issue(16'd65535, 8'd255);
        wait_done(0, lat);
        checks++;
        if (lat != 16 || dif.quotient !== 16'd257 || dif.remainder !== 8'd0) begin
            errors++; $display("FAIL ffff_by_255: got lat=%0d q=%0d r=%0d, expected lat=16 q=257 r=0",
                               lat, dif.quotient, dif.remainder);
        end
        checks++;
        if (int'(dif.quotient) * 255 + int'(dif.remainder) != 65535 || dif.remainder >= 8'd255) begin
            errors++; $display("FAIL ffff_by_255_invariant: got q=%0d r=%0d", dif.quotient, dif.remainder);
        end
        @(negedge clk);
    endtask

    task automatic test_div_zero();
        int lat;
        issue(16'h1234, 8'd0);
        wait_done(0, lat);
        checks++;
        if (lat != 1) begin
            errors++; $display("FAIL dz_latency: got %0d, expected 1", lat);
        end
        checks++;
        if (dif.div_by_zero !== 1'b1 || dif.quotient !== 16'hFFFF || dif.remainder !== 8'h34) begin
            errors++; $display("FAIL dz_result: got dz=%b q=%h r=%h, expected dz=1 q=ffff r=34",
                               dif.div_by_zero, dif.quotient, dif.remainder);
        end
        @(negedge clk);
        checks++;
        if (dif.done_flag !== 1'b0 || dif.busy !== 1'b0 || dif.div_by_zero !== 1'b1) begin
            errors++; $display("FAIL dz_after_done: got done=%b busy=%b dz=%b, expected done=0 busy=0 dz=1",
                               dif.done_flag, dif.busy, dif.div_by_zero);
        end
    endtask

    task automatic test_small();
        int lat;
        issue(16'd100, 8'd200);
        checks++;
        if (dif.div_by_zero !== 1'b0) begin
            errors++; $display("FAIL dz_cleared_on_start: got %b, expected 0", dif.div_by_zero);
        end
        wait_done(0, lat);
        checks++;
        if (lat != 16 || dif.quotient !== 16'd0 || dif.remainder !== 8'd100) begin
            errors++; $display("FAIL small_dividend: got lat=%0d q=%0d r=%0d, expected lat=16 q=0 r=100",
                               lat, dif.quotient, dif.remainder);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat;
        issue(16'd500, 8'd3);
        repeat (4) @(negedge clk);
        dif.start    = 1'b1;
        dif.dividend = 16'd9;
        dif.divisor  = 8'd2;
        @(negedge clk);
        dif.start    = 1'b0;
        wait_done(5, lat);
        checks++;
        if (lat != 16 || dif.quotient !== 16'd166 || dif.remainder !== 8'd2) begin
            errors++; $display("FAIL ignore_start_busy: got lat=%0d q=%0d r=%0d, expected lat=16 q=166 r=2",
                               lat, dif.quotient, dif.remainder);
        end
        checks++;
        if (int'(dif.quotient) * 3 + int'(dif.remainder) != 500 || dif.remainder >= 8'd3) begin
            errors++; $display("FAIL ignore_start_invariant: got q=%0d r=%0d", dif.quotient, dif.remainder);
        end
        dif.start    = 1'b1;
        dif.dividend = 16'd1000;
        dif.divisor  = 8'd7;
        @(negedge clk);
        checks++;
        if (dif.busy !== 1'b0) begin
            errors++; $display("FAIL held_start_e17: got busy=%b, expected 0", dif.busy);
        end
        @(negedge clk);
        checks++;
        if (dif.busy !== 1'b1) begin
            errors++; $display("FAIL held_start_e18: got busy=%b, expected 1", dif.busy);
        end
        dif.dividend = 16'd0;
        dif.divisor  = 8'd1;
        wait_done(0, lat);
        checks++;
        if (lat != 16 || dif.quotient !== 16'd142 || dif.remainder !== 8'd6) begin
            errors++; $display("FAIL held_start_result: got lat=%0d q=%0d r=%0d, expected lat=16 q=142 r=6",
                               lat, dif.quotient, dif.remainder);
        end
        dif.start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (dif.busy !== 1'b0 || dif.quotient !== 16'd142) begin
            errors++; $display("FAIL idle_after_release: got busy=%b q=%0d, expected busy=0 q=142",
                               dif.busy, dif.quotient);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        issue(16'd4000, 8'd9);
        repeat (7) @(negedge clk);
        #2;
        reset_a = 1'b0;
        #1;
        checks++;
        if ({dif.quotient, dif.remainder, dif.busy, dif.done_flag, dif.div_by_zero} !== 27'd0) begin
            errors++; $display("FAIL reset_mid_outputs: got q=%0d r=%0d busy=%b done=%b dz=%b, expected all 0",
                               dif.quotient, dif.remainder, dif.busy, dif.done_flag, dif.div_by_zero);
        end
        @(negedge clk);
        reset_a = 1'b1;
        @(negedge clk);
        issue(16'd4000, 8'd9);
        wait_done(0, lat);
        checks++;
        if (lat != 16 || dif.quotient !== 16'd444 || dif.remainder !== 8'd4) begin
            errors++; $display("FAIL after_reset_result: got lat=%0d q=%0d r=%0d, expected lat=16 q=444 r=4",
                               lat, dif.quotient, dif.remainder);
        end
        checks++;
        if (int'(dif.quotient) * 9 + int'(dif.remainder) != 4000 || dif.remainder >= 8'd9) begin
            errors++; $display("FAIL after_reset_invariant: got q=%0d r=%0d", dif.quotient, dif.remainder);
        end
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_extremes();
        test_div_zero();
        test_small();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
